// File: rtl/matvec_engine.sv
`default_nettype none
// ============================================================================
//  Module      : matvec_engine
//  Description : Signed matrix-vector multiplier, one column per clock,
//                all rows in parallel, with saturating or wrapping accumulate.
//  Revision    : 1.0 - initial release
// ============================================================================
module matvec_engine #(
    parameter int DW    = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int ACC_W = 20,
    parameter int SAT   = 1,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    input  logic [ROW_W+COL_W-1:0]   cfg_addr,
    input  logic [DW-1:0]            cfg_data,
    output logic                     cfg_err,
    input  logic                     start,
    input  logic [COLS*DW-1:0]       x_vector_flat,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ROWS*ACC_W-1:0]    result_flat
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic signed [DW-1:0]    x_q [COLS];
    logic signed [DW-1:0]    x_d [COLS];
    logic signed [DW-1:0]    w_q [ROWS][COLS];
    logic signed [DW-1:0]    w_d [ROWS][COLS];
    logic signed [ACC_W-1:0] acc_q [ROWS];
    logic signed [ACC_W-1:0] acc_d [ROWS];
    logic signed [ACC_W-1:0] acc_sum [ROWS];
    logic                    cfg_err_q, cfg_err_d;

    logic [ROW_W-1:0] cfg_row;
    logic [COL_W-1:0] cfg_col;
    logic [31:0]      cfg_row_ext, cfg_col_ext;
    logic             cfg_in_range;
    logic             cfg_we;
    logic             last_col;

    assign {cfg_row, cfg_col} = cfg_addr;
    assign cfg_row_ext  = 32'(cfg_row);
    assign cfg_col_ext  = 32'(cfg_col);
    assign cfg_in_range = (cfg_row_ext < 32'(ROWS)) && (cfg_col_ext < 32'(COLS));
    assign cfg_we       = cfg_valid && (state_q == S_IDLE) && cfg_in_range;
    assign last_col     = (32'(col_q) == 32'(COLS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_COMPUTE;
            S_COMPUTE: if (last_col) state_d = S_DONE;
            S_DONE:    if (res_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state_q == S_COMPUTE) || (state_q == S_DONE);
        res_valid = (state_q == S_DONE);
    end

    assign cfg_err = cfg_err_q;

    // One lane per row; the product is exact, only the running sum can overflow
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic signed [2*DW-1:0] prod;
        assign prod = w_q[r][col_q] * x_q[col_q];

        if (SAT != 0) begin : g_sat
            localparam int SUM_W = ACC_W + 1;
            logic signed [SUM_W-1:0] sum;
            assign sum = SUM_W'(prod) + SUM_W'(acc_q[r]);
            assign acc_sum[r] = (sum[ACC_W] != sum[ACC_W-1])
                              ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                            : {1'b0, {(ACC_W-1){1'b1}}})
                              : sum[ACC_W-1:0];
        end else begin : g_wrap
            assign acc_sum[r] = ACC_W'(prod) + acc_q[r];
        end

        assign result_flat[r*ACC_W +: ACC_W] = acc_q[r];
    end

    // Datapath next-state
    always_comb begin
        col_d     = col_q;
        x_d       = x_q;
        w_d       = w_q;
        acc_d     = acc_q;
        cfg_err_d = cfg_valid && !cfg_we;

        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (cfg_we && (cfg_row_ext == 32'(r)) && (cfg_col_ext == 32'(c))) begin
                    w_d[r][c] = cfg_data;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int c = 0; c < COLS; c++) begin
                        x_d[c] = x_vector_flat[c*DW +: DW];
                    end
                    for (int r = 0; r < ROWS; r++) begin
                        acc_d[r] = '0;
                    end
                    col_d = '0;
                end
            end
            S_COMPUTE: begin
                acc_d = acc_sum;
                col_d = last_col ? '0 : col_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            cfg_err_q <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                x_q[c] <= '0;
            end
            for (int r = 0; r < ROWS; r++) begin
                acc_q[r] <= '0;
                for (int c = 0; c < COLS; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else begin
            col_q     <= col_d;
            cfg_err_q <= cfg_err_d;
            x_q       <= x_d;
            w_q       <= w_d;
            acc_q     <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matvec_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matvec_engine
//  Description : Self-checking bench for matvec_engine (3x4, 16-bit acc,
//                saturating and wrapping instances driven in parallel).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matvec_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic [3:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        start;
    logic [31:0] x_vector_flat;
    logic        res_ready;

    logic        cfg_err_s, busy_s, res_valid_s;
    logic [47:0] result_s;
    logic        cfg_err_w, busy_w, res_valid_w;
    logic [47:0] result_w;

    int n_checks = 0;
    int n_pass   = 0;
    int mw [3][4];
    int mx [4];

    always #5 clk = ~clk;

    matvec_engine #(.DW(8), .ROWS(3), .COLS(4), .ACC_W(16), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_err(cfg_err_s), .start(start),
        .x_vector_flat(x_vector_flat), .busy(busy_s), .res_valid(res_valid_s),
        .res_ready(res_ready), .result_flat(result_s)
    );

    matvec_engine #(.DW(8), .ROWS(3), .COLS(4), .ACC_W(16), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_err(cfg_err_w), .start(start),
        .x_vector_flat(x_vector_flat), .busy(busy_w), .res_valid(res_valid_w),
        .res_ready(res_ready), .result_flat(result_w)
    );

    typedef struct packed {
        logic [31:0] x;
        logic [47:0] es;
        logic [47:0] ew;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dot product of one row computed from scratch, clamping or wrapping per add
    function automatic logic [15:0] model_row(input int r, input bit sat);
        longint acc = 0;
        logic [15:0] t;
        for (int c = 0; c < 4; c++) begin
            acc = acc + longint'(mw[r][c] * mx[c]);
            if (sat) begin
                if (acc > 32767) acc = 32767;
                else if (acc < -32768) acc = -32768;
            end else begin
                t   = acc[15:0];
                acc = longint'($signed(t));
            end
        end
        return acc[15:0];
    endfunction

    function automatic logic [31:0] pack_x();
        logic [31:0] v;
        int e;
        for (int c = 0; c < 4; c++) begin
            e = mx[c];
            v[c*8 +: 8] = e[7:0];
        end
        return v;
    endfunction

    task automatic write_w(input int r, input int c, input int v);
        cfg_valid = 1'b1;
        cfg_addr  = {2'(r), 2'(c)};
        cfg_data  = 8'(v);
        tick();
        cfg_valid = 1'b0;
        if (r < 3) mw[r][c] = v;
        chk("cfg_err_idle_write", 48'(cfg_err_s), 48'(r >= 3));
    endtask

    task automatic wait_done(inout int n);
        while (res_valid_s !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic check_results(input string tag);
        for (int r = 0; r < 3; r++) begin
            chk({tag, "_sat"},  48'(result_s[r*16 +: 16]), 48'(model_row(r, 1'b1)));
            chk({tag, "_wrap"}, 48'(result_w[r*16 +: 16]), 48'(model_row(r, 1'b0)));
        end
    endtask

    task automatic ack();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("busy_after_ack", 48'(busy_s), 48'd0);
        chk("valid_after_ack", 48'(res_valid_s), 48'd0);
    endtask

    task automatic kick();
        x_vector_flat = pack_x();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 48'(busy_s), 48'd1);
    endtask

    task automatic run_and_check(input string tag);
        int n;
        kick();
        n = 0;
        wait_done(n);
        chk({tag, "_latency"}, 48'(n), 48'd4);
        check_results(tag);
        ack();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [47:0] held;

        tbl[0] = '{x: 32'h08070605, es: {-16'sd3328, -16'sd70, 16'sd70},
                   ew: {-16'sd3328, -16'sd70, 16'sd70}};
        tbl[1] = '{x: 32'h80808080, es: {16'sd32767, 16'sd1280, -16'sd1280},
                   ew: {16'sd0, 16'sd1280, -16'sd1280}};
        tbl[2] = '{x: 32'h7f7f7f7f, es: {16'h8000, -16'sd1270, 16'sd1270},
                   ew: {16'sd512, -16'sd1270, 16'sd1270}};
        tbl[3] = '{x: 32'h00000000, es: 48'd0, ew: 48'd0};
        tbl[4] = '{x: 32'hff01ff01, es: {16'sd0, 16'sd2, -16'sd2},
                   ew: {16'sd0, 16'sd2, -16'sd2}};
        tbl[5] = '{x: 32'h807f7f7f, es: {-16'sd16384, -16'sd250, 16'sd250},
                   ew: {-16'sd32384, -16'sd250, 16'sd250}};

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; x_vector_flat = '0; res_ready = 1'b0;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 4; c++) mw[r][c] = 0;
        for (int c = 0; c < 4; c++) mx[c] = 0;

        tick(); tick();
        chk("rst_busy", 48'(busy_s), 48'd0);
        chk("rst_valid", 48'(res_valid_s), 48'd0);
        chk("rst_cfg_err", 48'(cfg_err_s), 48'd0);
        chk("rst_result_sat", result_s, 48'd0);
        chk("rst_result_wrap", result_w, 48'd0);
        rst_n = 1'b1;
        tick();

        // Fixed weight set used by the vector table
        for (int c = 0; c < 4; c++) begin
            write_w(0, c, c + 1);
            write_w(1, c, -(c + 1));
            write_w(2, c, -128);
        end
        write_w(3, 0, 55);
        tick();
        chk("cfg_err_clears", 48'(cfg_err_s), 48'd0);

        for (int i = 0; i < 6; i++) begin
            x_vector_flat = tbl[i].x;
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            wait_done(n);
            chk("tbl_latency", 48'(n), 48'd4);
            chk("tbl_result_sat", result_s, tbl[i].es);
            chk("tbl_result_wrap", result_w, tbl[i].ew);
            ack();
        end

        // Same-edge weight write and start: the new weight is used
        mx[0] = 0; mx[1] = 1; mx[2] = 0; mx[3] = 0;
        cfg_valid = 1'b1; cfg_addr = {2'd1, 2'd1}; cfg_data = 8'd9;
        mw[1][1] = 9;
        x_vector_flat = pack_x();
        start = 1'b1;
        tick();
        start = 1'b0; cfg_valid = 1'b0;
        chk("same_edge_cfg_err", 48'(cfg_err_s), 48'd0);
        n = 0;
        wait_done(n);
        chk("same_edge_latency", 48'(n), 48'd4);
        chk("same_edge_row1", 48'(result_s[16 +: 16]), 48'd9);
        check_results("same_edge");
        ack();

        // Write and restart during COMPUTE are rejected; x changes ignored
        mx[0] = 3; mx[1] = -7; mx[2] = 100; mx[3] = -128;
        kick();
        cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 8'd7;
        start = 1'b1; x_vector_flat = 32'h5a5a5a5a;
        tick();
        n = 1;
        cfg_valid = 1'b0; start = 1'b0;
        chk("busy_write_cfg_err", 48'(cfg_err_s), 48'd1);
        tick();
        n = 2;
        chk("busy_write_err_pulse", 48'(cfg_err_s), 48'd0);
        wait_done(n);
        chk("busy_write_latency", 48'(n), 48'd4);
        check_results("busy_write");

        // Hold in DONE with back-pressure
        held = result_s;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", 48'(res_valid_s), 48'd1);
            chk("hold_result", result_s, held);
        end
        ack();
        chk("idle_result_stable", result_s, held);

        // Randomized weights and vectors
        for (int it = 0; it < 25; it++) begin
            int k;
            k = int'($urandom_range(0, 3));
            for (int j = 0; j < k; j++) begin
                write_w(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                        (it % 4 == 0) ? -128 : int'($urandom_range(0, 255)) - 128);
            end
            for (int c = 0; c < 4; c++) begin
                mx[c] = (it % 5 == 0) ? ((c % 2 == 0) ? -128 : 127)
                                      : int'($urandom_range(0, 255)) - 128;
            end
            run_and_check("random");
        end

        // Reset mid-COMPUTE aborts and clears all state
        mx[0] = 11; mx[1] = 22; mx[2] = -33; mx[3] = 44;
        kick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 48'(busy_s), 48'd0);
        chk("abort_valid", 48'(res_valid_s), 48'd0);
        chk("abort_cfg_err", 48'(cfg_err_s), 48'd0);
        chk("abort_result", result_s, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 4; c++) mw[r][c] = 0;
        tick();
        mx[0] = 99; mx[1] = -99; mx[2] = 127; mx[3] = -128;
        run_and_check("post_reset");
        chk("post_reset_zero", result_s, 48'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
